// File: rtl/tl_tx_ecrc_gen.sv
// TX End-to-End CRC generator: accumulates CRC-32 over each TLP and appends the ECRC digest.
// Optional macro TL_TX_ECRC_ERR_INJ_EN adds i_err_inj (flips digest bit 0 for the TLP).
module tl_tx_ecrc_gen #(
    parameter int DATA_WIDTH       = 256,
    parameter int VALID_DATA_WIDTH = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_cfg_ecrc_gen_en,
    input  logic [DATA_WIDTH-1:0]       i_data,
    input  logic                        i_sop,
    input  logic                        i_eop,
    input  logic [VALID_DATA_WIDTH-1:0] i_length,
    input  logic                        i_td,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic [DATA_WIDTH-1:0]       o_data,
    output logic                        o_sop,
    output logic                        o_eop,
    output logic [VALID_DATA_WIDTH-1:0] o_length,
    output logic                        o_valid,
    input  logic                        i_ready
`ifdef TL_TX_ECRC_ERR_INJ_EN
   ,input  logic                        i_err_inj
`endif
);

    localparam int          NUM_DW   = DATA_WIDTH / 32;
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_SEED = 32'hFFFF_FFFF;

    typedef enum logic {ST_PASS, ST_XTRA} state_t;

    state_t      state_q;
    logic [31:0] crc_q;
    logic        gen_q;
    logic        accept;
    logic        gen_cur;
    logic        inj_cur;
    logic        full_eop;
    logic [VALID_DATA_WIDTH-1:0] last_dw;
    logic [DATA_WIDTH-1:0]       crc_data;
    logic [DATA_WIDTH-1:0]       ins_data;
    logic [31:0] crc_next;
    logic [31:0] digest;

`ifdef TL_TX_ECRC_ERR_INJ_EN
    logic inj_q;
    assign inj_cur = i_sop ? (i_err_inj & i_td & i_cfg_ecrc_gen_en) : inj_q;
`else
    assign inj_cur = 1'b0;
`endif

    assign o_ready  = (~o_valid | i_ready) & (state_q == ST_PASS);
    assign accept   = i_valid & o_ready;
    assign gen_cur  = i_sop ? (i_td & i_cfg_ecrc_gen_en) : gen_q;
    assign full_eop = &i_length;
    assign last_dw  = i_eop ? i_length : VALID_DATA_WIDTH'(NUM_DW - 1);
    assign digest   = crc_next ^ {31'b0, inj_cur};

    // Type[0] and EP are treated as 1 for the CRC only, so the digest survives EP poisoning en route.
    always_comb begin
        crc_data = i_data;
        if (i_sop) begin
            crc_data[DATA_WIDTH-8]  = 1'b1;
            crc_data[DATA_WIDTH-18] = 1'b1;
        end
    end

    always_comb begin
        logic [DATA_WIDTH-1:0] sh;
        logic [31:0]           c;
        logic                  fb;
        sh = crc_data;
        c  = i_sop ? CRC_SEED : crc_q;
        fb = 1'b0;
        for (int unsigned dw = 0; dw < NUM_DW; dw++) begin
            for (int unsigned b = 0; b < 32; b++) begin
                if (dw <= 32'(last_dw)) begin
                    fb = c[31] ^ sh[DATA_WIDTH-1];
                    c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : '0);
                end
                sh = sh << 1;
            end
        end
        crc_next = c;
    end

    always_comb begin
        logic [DATA_WIDTH-1:0] sh;
        logic [31:0]           w;
        sh       = i_data;
        ins_data = '0;
        for (int unsigned dw = 0; dw < NUM_DW; dw++) begin
            w  = sh[DATA_WIDTH-1 -: 32];
            sh = sh << 32;
            if (dw <= 32'(i_length))
                ins_data = {ins_data[DATA_WIDTH-33:0], w};
            else if (dw == 32'(i_length) + 32'd1)
                ins_data = {ins_data[DATA_WIDTH-33:0], digest};
            else
                ins_data = {ins_data[DATA_WIDTH-33:0], 32'h0};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_PASS;
            crc_q    <= CRC_SEED;
            gen_q    <= 1'b0;
            o_valid  <= 1'b0;
            o_sop    <= 1'b0;
            o_eop    <= 1'b0;
            o_length <= '0;
            o_data   <= '0;
`ifdef TL_TX_ECRC_ERR_INJ_EN
            inj_q    <= 1'b0;
`endif
        end else begin
            if (o_valid && i_ready)
                o_valid <= 1'b0;
            case (state_q)
                ST_PASS: begin
                    if (accept) begin
                        o_valid  <= 1'b1;
                        o_sop    <= i_sop;
                        o_eop    <= i_eop;
                        o_length <= i_length;
                        o_data   <= i_data;
                        gen_q    <= gen_cur;
                        crc_q    <= crc_next;
`ifdef TL_TX_ECRC_ERR_INJ_EN
                        inj_q    <= inj_cur;
`endif
                        if (i_eop && gen_cur) begin
                            if (full_eop) begin
                                // No free slot: park the digest in crc_q for the extra beat.
                                o_eop   <= 1'b0;
                                crc_q   <= digest;
                                state_q <= ST_XTRA;
                            end else begin
                                o_data   <= ins_data;
                                o_length <= i_length + VALID_DATA_WIDTH'(1);
                            end
                        end
                    end
                end
                ST_XTRA: begin
                    if (!o_valid || i_ready) begin
                        o_valid  <= 1'b1;
                        o_sop    <= 1'b0;
                        o_eop    <= 1'b1;
                        o_length <= '0;
                        o_data   <= {crc_q, {(DATA_WIDTH-32){1'b0}}};
                        state_q  <= ST_PASS;
                    end
                end
                default: state_q <= ST_PASS;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_tx_ecrc_gen.sv
// Bench for tl_tx_ecrc_gen: directed + random TLPs scored against a DW-queue ECRC model.
// Honours TL_TX_ECRC_ERR_INJ_EN when defined.
module tb_tl_tx_ecrc_gen;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b0;
    logic         i_cfg_ecrc_gen_en = 1'b0;
    logic [255:0] i_data = '0;
    logic         i_sop = 1'b0, i_eop = 1'b0, i_td = 1'b0, i_valid = 1'b0;
    logic [2:0]   i_length = '0;
    logic         o_ready, o_sop, o_eop, o_valid;
    logic [255:0] o_data;
    logic [2:0]   o_length;
    logic         i_ready;
    logic         man_ready = 1'b1, rnd_ready = 1'b1, bp_rand = 1'b0;
`ifdef TL_TX_ECRC_ERR_INJ_EN
    logic         i_err_inj = 1'b0;
`endif

    assign i_ready = bp_rand ? rnd_ready : man_ready;

    tl_tx_ecrc_gen #(.DATA_WIDTH(256), .VALID_DATA_WIDTH(3)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cfg_ecrc_gen_en(i_cfg_ecrc_gen_en),
        .i_data(i_data), .i_sop(i_sop), .i_eop(i_eop), .i_length(i_length),
        .i_td(i_td), .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data),
        .o_sop(o_sop), .o_eop(o_eop), .o_length(o_length), .o_valid(o_valid),
        .i_ready(i_ready)
`ifdef TL_TX_ECRC_ERR_INJ_EN
       ,.i_err_inj(i_err_inj)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [255:0] data;
        logic         sop;
        logic         eop;
        logic [2:0]   len;
        int           dslot;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] tlp_dw[$];
    logic [31:0] last_dig = '0;
    int          checks = 0, failures = 0;
    int          rl_cnt = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ECRC straight from the rule: seeded, MSB-first over every DW, variant bits forced in DW0.
    function automatic logic [31:0] model_crc(input logic [31:0] dws[$]);
        logic [31:0] c;
        logic [31:0] w;
        logic        m;
        c = 32'hFFFF_FFFF;
        foreach (dws[i]) begin
            w = dws[i];
            if (i == 0) w = w | 32'h0100_4000;
            for (int b = 31; b >= 0; b--) begin
                m = c[31] ^ w[b];
                c = c << 1;
                if (m) c = c ^ 32'h04C1_1DB7;
            end
        end
        return c;
    endfunction

    task automatic fill(input int n);
        tlp_dw.delete();
        for (int i = 0; i < n; i++) tlp_dw.push_back($urandom);
    endtask

    task automatic drive_beat(input logic [255:0] d, input logic sop, input logic eop,
                              input logic [2:0] len, input logic td, input logic gen_en,
                              input logic inj);
        logic acc;
        acc = 1'b0;
        @(negedge i_clk);
        i_data = d; i_sop = sop; i_eop = eop; i_length = len; i_td = td;
        i_cfg_ecrc_gen_en = gen_en; i_valid = 1'b1;
`ifdef TL_TX_ECRC_ERR_INJ_EN
        i_err_inj = inj;
`endif
        for (int t = 0; t < 100 && !acc; t++) begin
            if (t > 0) @(negedge i_clk);
            #1 acc = o_ready;
            @(posedge i_clk);
        end
        chk("accept_timeout", {255'b0, acc}, 256'd1);
    endtask

    task automatic send_tlp(input logic td, input logic gen_en, input logic inj, input int stop_after);
        int           n, nb, li;
        logic         gen, eop;
        logic [31:0]  crc;
        logic [255:0] d, ed;
        beat_t        e;
        n   = tlp_dw.size();
        nb  = (n + 7) / 8;
        gen = td & gen_en;
        crc = model_crc(tlp_dw) ^ {31'b0, inj & gen};
        for (int k = 0; k < nb && k < stop_after; k++) begin
            for (int j = 0; j < 8; j++)
                d[255-32*j -: 32] = (k*8 + j < n) ? tlp_dw[k*8 + j] : $urandom;
            eop = (k == nb - 1);
            li  = eop ? (n - 1 - 8*k) : 7;
            drive_beat(d, k == 0, eop, 3'(li), td, gen_en, inj);
            e.sop = (k == 0); e.dslot = -1;
            if (!(eop && gen)) begin
                e.data = d; e.eop = eop; e.len = 3'(li);
                exp_q.push_back(e);
            end else if (li < 7) begin
                ed = d;
                for (int j = li + 1; j < 8; j++) ed[255-32*j -: 32] = 32'h0;
                ed[255-32*(li+1) -: 32] = crc;
                e.data = ed; e.eop = 1'b1; e.len = 3'(li + 1); e.dslot = li + 1;
                exp_q.push_back(e);
            end else begin
                e.data = d; e.eop = 1'b0; e.len = 3'd7;
                exp_q.push_back(e);
                e.data = {crc, 224'h0}; e.sop = 1'b0; e.eop = 1'b1; e.len = 3'd0; e.dslot = 0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle();
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(negedge i_clk);
        repeat (2) @(negedge i_clk);
        chk("drain_pending", 256'(exp_q.size()), 256'd0);
    endtask

    always @(negedge i_clk) rnd_ready = ($urandom_range(3) != 0);

    always @(negedge i_clk) begin
        beat_t e;
        #1;
        if (!i_rst && !o_ready) rl_cnt++;
        if (!i_rst && o_valid && i_ready) begin
            chk("unexpected_beat", 256'(exp_q.size() != 0), 256'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("o_data", o_data, e.data);
                chk("o_sop", 256'(o_sop), 256'(e.sop));
                chk("o_eop", 256'(o_eop), 256'(e.eop));
                chk("o_length", 256'(o_length), 256'(e.len));
                if (e.dslot >= 0) last_dig = o_data[255-32*e.dslot -: 32];
            end
        end
    end

    initial begin
        logic [31:0] dig_a;
        int          rl0;
        #1 i_rst = 1'b1;
        #5;
        chk("rst_o_valid", 256'(o_valid), 256'd0);
        chk("rst_o_sop", 256'(o_sop), 256'd0);
        chk("rst_o_eop", 256'(o_eop), 256'd0);
        chk("rst_o_length", 256'(o_length), 256'd0);
        chk("rst_o_data", o_data, 256'd0);
        @(negedge i_clk) i_rst = 1'b0;
        #1 chk("rst_o_ready", 256'(o_ready), 256'd1);

        // 3DW header + 1DW payload, single beat
        fill(4); send_tlp(1'b1, 1'b1, 1'b0, 99); idle(); drain();

        // 16 DWs: full EOP beat forces an extra digest beat and one ready bubble
        rl0 = rl_cnt;
        fill(16); send_tlp(1'b1, 1'b1, 1'b0, 99); idle(); drain();
        chk("ready_bubble", 256'(rl_cnt - rl0), 256'd1);

        // pass-through: td=0, then gen disabled
        fill(16); send_tlp(1'b0, 1'b1, 1'b0, 99); idle(); drain();
        fill(11); send_tlp(1'b1, 1'b0, 1'b0, 99); idle(); drain();

        // EP / Type[0] variants yield identical digests
        fill(6);
        tlp_dw[0][24] = 1'b0; tlp_dw[0][14] = 1'b0;
        send_tlp(1'b1, 1'b1, 1'b0, 99); idle(); drain();
        dig_a = last_dig;
        tlp_dw[0][24] = 1'b1; tlp_dw[0][14] = 1'b1;
        send_tlp(1'b1, 1'b1, 1'b0, 99); idle(); drain();
        chk("variant_digest", 256'(last_dig), 256'(dig_a));

        // backpressure during XTRA with a new SOP waiting
        fill(16); send_tlp(1'b1, 1'b1, 1'b0, 99);
        fill(5);
        fork
            begin #1 man_ready = 1'b0; repeat (5) @(negedge i_clk); man_ready = 1'b1; end
            send_tlp(1'b1, 1'b1, 1'b0, 99);
        join
        idle(); drain();

        // SOP while a TLP is open abandons it
        fill(16); send_tlp(1'b1, 1'b1, 1'b0, 1);
        fill(3); send_tlp(1'b1, 1'b1, 1'b0, 99); idle(); drain();

        // reset mid-TLP drops output immediately
        fill(16); send_tlp(1'b1, 1'b1, 1'b0, 1);
        #1 i_rst = 1'b1; i_valid = 1'b0;
        exp_q.delete();
        #1 chk("midrst_o_valid", 256'(o_valid), 256'd0);
        @(negedge i_clk) chk("midrst_o_valid_hold", 256'(o_valid), 256'd0);
        @(negedge i_clk) i_rst = 1'b0;
        fill(6); send_tlp(1'b1, 1'b1, 1'b0, 99); idle(); drain();

`ifdef TL_TX_ECRC_ERR_INJ_EN
        fill(4); send_tlp(1'b1, 1'b1, 1'b1, 99); idle(); drain();
        fill(8); send_tlp(1'b1, 1'b1, 1'b1, 99); idle(); drain();
`endif

        // random TLPs under random backpressure
        bp_rand = 1'b1;
        for (int i = 0; i < 30; i++) begin
            fill($urandom_range(1, 24));
`ifdef TL_TX_ECRC_ERR_INJ_EN
            send_tlp($urandom_range(3) != 0, $urandom_range(3) != 0, 1'($urandom_range(1)), 99);
`else
            send_tlp($urandom_range(3) != 0, $urandom_range(3) != 0, 1'b0, 99);
`endif
            if ($urandom_range(1) == 1) idle();
        end
        idle(); drain();
        bp_rand = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
